// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle carrying a datapath word and a control word.
// master drives valid/data/ctrl, slave drives ready.
interface pipe_skid_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;

    modport master (output valid, output data, output ctrl, input  ready);
    modport slave  (input  valid, input  data, input  ctrl, output ready);
endinterface

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a two-entry skid buffer, flush, and zeroed control on bubbles.
// Every output is decoded from registered state only.
module pipe_skid_stage #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned CTRL_W    = 8,
    parameter bit          ZERO_DATA = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                flush,
    pipe_skid_stage_if.slave    in_bus,
    pipe_skid_stage_if.master   out_bus,
    output logic [1:0]          occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
    logic              accept, drain;
    logic              load_main_in, load_main_skid, load_skid_in, zero_regs;

    always_comb begin
        state_nx       = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        zero_regs      = 1'b0;
        accept         = in_bus.valid && (state != SKID);
        drain          = (state != EMPTY) && out_bus.ready;

        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nx     = FULL;
                    load_main_in = 1'b1;
                end
            end
            FULL: begin
                if (accept && drain) begin
                    load_main_in = 1'b1;
                end else if (drain) begin
                    state_nx = EMPTY;
                end else if (accept) begin
                    state_nx     = SKID;
                    load_skid_in = 1'b1;
                end
            end
            SKID: begin
                if (drain) begin
                    state_nx       = FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase

        // Flush discards any same-cycle accept; a same-cycle drain was already taken downstream.
        if (flush) begin
            state_nx       = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
            zero_regs      = ZERO_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= EMPTY;
            main_data <= '0;
            main_ctrl <= '0;
            skid_data <= '0;
            skid_ctrl <= '0;
        end else begin
            state <= state_nx;
            if (zero_regs) begin
                main_data <= '0;
                main_ctrl <= '0;
                skid_data <= '0;
                skid_ctrl <= '0;
            end else begin
                if (load_main_in) begin
                    main_data <= in_bus.data;
                    main_ctrl <= in_bus.ctrl;
                end else if (load_main_skid) begin
                    main_data <= skid_data;
                    main_ctrl <= skid_ctrl;
                end
                if (load_skid_in) begin
                    skid_data <= in_bus.data;
                    skid_ctrl <= in_bus.ctrl;
                end
            end
        end
    end

    always_comb begin
        in_bus.ready  = (state != SKID);
        out_bus.valid = (state != EMPTY);
        out_bus.ctrl  = (state != EMPTY) ? main_ctrl : '0;
        out_bus.data  = (ZERO_DATA && (state == EMPTY)) ? '0 : main_data;
        case (state)
            FULL:    occupancy = 2'd1;
            SKID:    occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule
